// File: rtl/ssc_mem_arb_pkg.sv
// Shared types and constants for the two-channel arbitrated word memory.
package ssc_mem_pkg;

    localparam int unsigned MAX_READ_LAT = 4;
    // Pipeline entries carry data zero-extended to this width (DATA_W <= 64)
    localparam int unsigned MAX_DATA_W   = 64;

    typedef logic chan_t;
    localparam chan_t CH0 = 1'b0;
    localparam chan_t CH1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        GNT0,
        GNT1
    } arb_state_t;

    typedef struct packed {
        logic                  valid;
        chan_t                 chan;
        logic [MAX_DATA_W-1:0] data;
        logic                  perr;
    } pipe_entry_t;

endpackage

// File: rtl/ssc_mem_arb_rr_arb2.sv
// Two-requester round-robin arbiter: immediate grant for a lone requester,
// alternating grants under contention via a registered priority pointer.
module ssc_rr_arb2
    import ssc_mem_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req0_i,
    input  logic req1_i,
    output logic gnt0_o,
    output logic gnt1_o
);

    chan_t      prio_q;
    chan_t      prio_d;
    arb_state_t arb_state;

    // Priority pointer register
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= CH0;
        end else begin
            prio_q <= prio_d;
        end
    end

    // Grant decision for this cycle; pointer flips only on contention
    always_comb begin
        arb_state = IDLE;
        prio_d    = prio_q;
        case ({req1_i, req0_i})
            2'b01:   arb_state = GNT0;
            2'b10:   arb_state = GNT1;
            2'b11: begin
                arb_state = (prio_q == CH0) ? GNT0 : GNT1;
                prio_d    = ~prio_q;
            end
            default: arb_state = IDLE;
        endcase
    end

    // One-hot grant outputs
    always_comb begin
        gnt0_o = (arb_state == GNT0);
        gnt1_o = (arb_state == GNT1);
    end

endmodule

// File: rtl/ssc_mem_arb.sv
// Two-channel single-port word memory with round-robin arbitration and a
// READ_LAT-deep read pipeline. Define SSC_MEM_PARITY_EN to store an even
// parity bit per word and flag mismatches on read.
module ssc_mem_arb
    import ssc_mem_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read_0,
    input  logic              read_1,
    input  logic              write_0,
    input  logic              write_1,
    input  logic [ADDR_W-1:0] address_0,
    input  logic [ADDR_W-1:0] address_1,
    input  logic [DATA_W-1:0] Write_data_0,
    input  logic [DATA_W-1:0] Write_data_1,
    input  logic              par_inj_0,
    input  logic              par_inj_1,
    output logic              ack_0,
    output logic              ack_1,
    output logic [DATA_W-1:0] Read_data_0,
    output logic [DATA_W-1:0] Read_data_1,
    output logic              rvalid_0,
    output logic              rvalid_1,
    output logic              par_err_0,
    output logic              par_err_1,
    output logic              req_err_0,
    output logic              req_err_1,
    output logic              busy
);

    localparam int unsigned LAT = (READ_LAT < 1) ? 1 :
                                  ((READ_LAT > MAX_READ_LAT) ? MAX_READ_LAT : READ_LAT);
    localparam int unsigned IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef SSC_MEM_PARITY_EN
    localparam int unsigned MW  = DATA_W + 1;
`else
    localparam int unsigned MW  = DATA_W;
`endif

    logic              req0, req1, gnt0, gnt1;
    logic              sel_wr, sel_rd, in_range;
    chan_t             sel_chan;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [IW-1:0]     mem_idx;
    logic [MW-1:0]     wword, rword;
    logic [MW-1:0]     mem_q [DEPTH];
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    pipe_entry_t       new_e, tail_in, last;
    pipe_entry_t       pipe_q [1:LAT];
    pipe_entry_t       st     [0:LAT];
    logic              unused_tail;

    // Requests are masked during reset so nothing is granted
    assign req0 = ~rst & (read_0 | write_0);
    assign req1 = ~rst & (read_1 | write_1);

    ssc_rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req0_i (req0),
        .req1_i (req1),
        .gnt0_o (gnt0),
        .gnt1_o (gnt1)
    );

    assign ack_0     = gnt0;
    assign ack_1     = gnt1;
    assign req_err_0 = gnt0 & read_0 & write_0;
    assign req_err_1 = gnt1 & read_1 & write_1;

    // Mux the granted channel's request; read+write together counts as a write
    always_comb begin
        sel_chan  = gnt1 ? CH1 : CH0;
        sel_addr  = gnt1 ? address_1 : address_0;
        sel_wdata = gnt1 ? Write_data_1 : Write_data_0;
        sel_wr    = (gnt0 & write_0) | (gnt1 & write_1);
        sel_rd    = ((gnt0 & read_0) | (gnt1 & read_1)) & ~sel_wr;
    end

    assign in_range = (32'(sel_addr) < DEPTH);
    assign mem_idx  = sel_addr[IW-1:0];
    assign rword    = mem_q[mem_idx];

`ifdef SSC_MEM_PARITY_EN
    logic sel_inj;
    assign sel_inj = gnt1 ? par_inj_1 : par_inj_0;
    assign wword   = {(^sel_wdata) ^ sel_inj, sel_wdata};
`else
    logic unused_inj;
    assign unused_inj = par_inj_0 ^ par_inj_1;
    assign wword      = sel_wdata;
`endif

    // Array write; out-of-range addresses are dropped
    always_ff @(posedge clk) begin
        if (sel_wr && in_range) begin
            mem_q[mem_idx] <= wword;
        end
    end

    // New pipeline entry from the committed read; out-of-range reads return 0
    always_comb begin
        new_e       = '0;
        new_e.valid = sel_rd;
        new_e.chan  = sel_chan;
        if (in_range) begin
            new_e.data = MAX_DATA_W'(rword[DATA_W-1:0]);
`ifdef SSC_MEM_PARITY_EN
            new_e.perr = rword[DATA_W] ^ (^rword[DATA_W-1:0]);
`endif
        end
    end

    // Stage view: st[0] is the entry being committed, st[LAT] the output stage
    always_comb begin
        st[0] = new_e;
        for (int unsigned i = 1; i <= LAT; i++) begin
            st[i] = pipe_q[i];
        end
    end

    assign tail_in     = st[LAT-1];
    assign last        = st[LAT];
    assign unused_tail = ^{last.data, last.perr};

    // Read pipeline shift; reset drops any reads in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 1; i <= LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 1; i <= LAT; i++) begin
                pipe_q[i] <= st[i-1];
            end
        end
    end

    // Capture read data as it enters the output stage; holds between pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else if (tail_in.valid) begin
            if (tail_in.chan == CH0) begin
                rdata0_q <= tail_in.data[DATA_W-1:0];
            end else begin
                rdata1_q <= tail_in.data[DATA_W-1:0];
            end
        end
    end

    assign Read_data_0 = rdata0_q;
    assign Read_data_1 = rdata1_q;
    assign rvalid_0    = last.valid & (last.chan == CH0);
    assign rvalid_1    = last.valid & (last.chan == CH1);

`ifdef SSC_MEM_PARITY_EN
    assign par_err_0 = rvalid_0 & last.perr;
    assign par_err_1 = rvalid_1 & last.perr;
`else
    assign par_err_0 = 1'b0;
    assign par_err_1 = 1'b0;
`endif

    // Busy while any pipeline stage holds a read
    always_comb begin
        busy = 1'b0;
        for (int unsigned i = 1; i <= LAT; i++) begin
            busy = busy | pipe_q[i].valid;
        end
    end

endmodule

// File: tb/tb_ssc_mem_arb.sv
// Directed bench for ssc_mem_arb: one instance with DEPTH=200/READ_LAT=1 and
// one with DEPTH=256/READ_LAT=3, both driven by the same requests.
module tb_ssc_mem_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        read_0, read_1, write_0, write_1, par_inj_0, par_inj_1;
    logic [7:0]  address_0, address_1;
    logic [15:0] Write_data_0, Write_data_1;

    logic        a_ack_0, a_ack_1, a_rvalid_0, a_rvalid_1, a_par_err_0, a_par_err_1;
    logic        a_req_err_0, a_req_err_1, a_busy;
    logic [15:0] a_Read_data_0, a_Read_data_1;
    logic        b_ack_0, b_ack_1, b_rvalid_0, b_rvalid_1, b_par_err_0, b_par_err_1;
    logic        b_req_err_0, b_req_err_1, b_busy;
    logic [15:0] b_Read_data_0, b_Read_data_1;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

`ifdef SSC_MEM_PARITY_EN
    localparam logic EXP_PERR = 1'b1;
`else
    localparam logic EXP_PERR = 1'b0;
`endif

    always #5 clk = ~clk;

    ssc_mem_arb #(.DATA_W(16), .ADDR_W(8), .DEPTH(200), .READ_LAT(1)) u_a (
        .clk(clk), .rst(rst),
        .read_0(read_0), .read_1(read_1), .write_0(write_0), .write_1(write_1),
        .address_0(address_0), .address_1(address_1),
        .Write_data_0(Write_data_0), .Write_data_1(Write_data_1),
        .par_inj_0(par_inj_0), .par_inj_1(par_inj_1),
        .ack_0(a_ack_0), .ack_1(a_ack_1),
        .Read_data_0(a_Read_data_0), .Read_data_1(a_Read_data_1),
        .rvalid_0(a_rvalid_0), .rvalid_1(a_rvalid_1),
        .par_err_0(a_par_err_0), .par_err_1(a_par_err_1),
        .req_err_0(a_req_err_0), .req_err_1(a_req_err_1),
        .busy(a_busy)
    );

    ssc_mem_arb #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .READ_LAT(3)) u_b (
        .clk(clk), .rst(rst),
        .read_0(read_0), .read_1(read_1), .write_0(write_0), .write_1(write_1),
        .address_0(address_0), .address_1(address_1),
        .Write_data_0(Write_data_0), .Write_data_1(Write_data_1),
        .par_inj_0(par_inj_0), .par_inj_1(par_inj_1),
        .ack_0(b_ack_0), .ack_1(b_ack_1),
        .Read_data_0(b_Read_data_0), .Read_data_1(b_Read_data_1),
        .rvalid_0(b_rvalid_0), .rvalid_1(b_rvalid_1),
        .par_err_0(b_par_err_0), .par_err_1(b_par_err_1),
        .req_err_0(b_req_err_0), .req_err_1(b_req_err_1),
        .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drv0(input logic rd, input logic wr, input logic [7:0] a,
                        input logic [15:0] d, input logic inj);
        read_0 = rd; write_0 = wr; address_0 = a; Write_data_0 = d; par_inj_0 = inj;
    endtask

    task automatic drv1(input logic rd, input logic wr, input logic [7:0] a,
                        input logic [15:0] d, input logic inj);
        read_1 = rd; write_1 = wr; address_1 = a; Write_data_1 = d; par_inj_1 = inj;
    endtask

    task automatic idle();
        drv0(1'b0, 1'b0, 8'd0, 16'h0, 1'b0);
        drv1(1'b0, 1'b0, 8'd0, 16'h0, 1'b0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] a0, a1;
        logic       ev;

        // Reset: a request presented during reset must not be granted
        rst = 1'b1;
        idle();
        next_cycle();
        drv0(1'b1, 1'b0, 8'd5, 16'h0, 1'b0);
        #2;
        chk("rst_ack0", a_ack_0, 1'b0);
        chk("rst_rvalid0", a_rvalid_0, 1'b0);
        chk("rst_rdata0", a_Read_data_0, 16'h0);
        chk("rst_busy_a", a_busy, 1'b0);
        chk("rst_busy_b", b_busy, 1'b0);
        chk("rst_reqerr0", a_req_err_0, 1'b0);
        next_cycle();
        rst = 1'b0;

        // Write 0x1234 to addr 5, then read it back
        drv0(1'b0, 1'b1, 8'd5, 16'h1234, 1'b0);
        #2;
        chk("wr5_ack0", a_ack_0, 1'b1);
        chk("wr5_ack1", a_ack_1, 1'b0);
        chk("wr5_reqerr0", a_req_err_0, 1'b0);
        next_cycle();
        drv0(1'b1, 1'b0, 8'd5, 16'h0, 1'b0);
        #2;
        chk("rd5_ack0", a_ack_0, 1'b1);
        next_cycle();
        idle();
        #2;
        chk("rd5_rvalid_a", a_rvalid_0, 1'b1);
        chk("rd5_rdata_a", a_Read_data_0, 16'h1234);
        chk("rd5_perr_a", a_par_err_0, 1'b0);
        chk("rd5_busy_a", a_busy, 1'b1);
        chk("rd5_rvalid_b_early", b_rvalid_0, 1'b0);
        chk("rd5_busy_b", b_busy, 1'b1);
        next_cycle();
        #2;
        chk("rd5_rvalid_a_pulse", a_rvalid_0, 1'b0);
        chk("rd5_rdata_a_hold", a_Read_data_0, 16'h1234);
        chk("rd5_busy_a_clr", a_busy, 1'b0);
        next_cycle();
        #2;
        chk("rd5_rvalid_b", b_rvalid_0, 1'b1);
        chk("rd5_rdata_b", b_Read_data_0, 16'h1234);
        next_cycle();
        #2;
        chk("rd5_rvalid_b_pulse", b_rvalid_0, 1'b0);
        chk("rd5_busy_b_clr", b_busy, 1'b0);

        // Contention: ch0 writes 20..23, ch1 reads 20..23; grants alternate from ch0
        for (int k = 0; k < 8; k++) begin
            a0 = 8'(20 + (k + 1) / 2);
            a1 = 8'(20 + k / 2);
            drv0(1'b0, 1'b1, a0, 16'hC000 + 16'(a0), 1'b0);
            drv1(1'b1, 1'b0, a1, 16'h0, 1'b0);
            #2;
            ev = (k >= 2) && (k % 2 == 0);
            chk($sformatf("rr_ack0_k%0d", k), a_ack_0, (k % 2 == 0));
            chk($sformatf("rr_ack1_k%0d", k), a_ack_1, (k % 2 == 1));
            chk($sformatf("rr_rvalid1_k%0d", k), a_rvalid_1, ev);
            if (ev)
                chk($sformatf("rr_rdata1_k%0d", k), a_Read_data_1, 16'hC000 + 16'(20 + k / 2 - 1));
            next_cycle();
        end
        drv0(1'b0, 1'b1, 8'd24, 16'hC018, 1'b0);
        drv1(1'b0, 1'b0, 8'd0, 16'h0, 1'b0);
        #2;
        chk("rr_tail_ack0", a_ack_0, 1'b1);
        chk("rr_tail_rvalid1", a_rvalid_1, 1'b1);
        chk("rr_tail_rdata1", a_Read_data_1, 16'hC017);
        next_cycle();
        idle();
        next_cycle();
        #2;
        chk("rr_b_rvalid1", b_rvalid_1, 1'b1);
        chk("rr_b_rdata1", b_Read_data_1, 16'hC017);
        next_cycle();
        #2;
        chk("rr_b_busy_clr", b_busy, 1'b0);

        // READ_LAT=3 back-to-back reads of addr 1,2,3 holding 0xA,0xB,0xC
        for (int i = 1; i <= 3; i++) begin
            drv0(1'b0, 1'b1, 8'(i), 16'(9 + i), 1'b0);
            #2;
            chk($sformatf("pre_ack0_%0d", i), a_ack_0, 1'b1);
            next_cycle();
        end
        idle();
        for (int k = 0; k < 7; k++) begin
            if (k < 3) drv1(1'b1, 1'b0, 8'(k + 1), 16'h0, 1'b0);
            else       drv1(1'b0, 1'b0, 8'd0, 16'h0, 1'b0);
            #2;
            if (k < 3) chk($sformatf("b2b_ack1_k%0d", k), b_ack_1, 1'b1);
            chk($sformatf("b2b_busy_b_k%0d", k), b_busy, (k >= 1 && k <= 5));
            chk($sformatf("b2b_rvalid_b_k%0d", k), b_rvalid_1, (k >= 3 && k <= 5));
            chk($sformatf("b2b_rvalid_a_k%0d", k), a_rvalid_1, (k >= 1 && k <= 3));
            if (k >= 3)
                chk($sformatf("b2b_rdata_b_k%0d", k), b_Read_data_1, (k >= 5) ? 16'hC : 16'(7 + k));
            if (k >= 1 && k <= 3)
                chk($sformatf("b2b_rdata_a_k%0d", k), a_Read_data_1, 16'(9 + k));
            next_cycle();
        end

        // Out-of-range: addr 250 on DEPTH=200 must neither store nor alias addr 50
        drv0(1'b0, 1'b1, 8'd50, 16'h5050, 1'b0);
        #2;
        chk("oor_wr50_ack", a_ack_0, 1'b1);
        next_cycle();
        drv0(1'b0, 1'b1, 8'd250, 16'hDEAD, 1'b0);
        #2;
        chk("oor_wr250_ack", a_ack_0, 1'b1);
        next_cycle();
        drv0(1'b1, 1'b0, 8'd250, 16'h0, 1'b0);
        #2;
        chk("oor_rd250_ack", a_ack_0, 1'b1);
        next_cycle();
        drv0(1'b1, 1'b0, 8'd50, 16'h0, 1'b0);
        #2;
        chk("oor_rd250_rvalid_a", a_rvalid_0, 1'b1);
        chk("oor_rd250_rdata_a", a_Read_data_0, 16'h0);
        next_cycle();
        idle();
        #2;
        chk("oor_rd50_rvalid_a", a_rvalid_0, 1'b1);
        chk("oor_rd50_rdata_a", a_Read_data_0, 16'h5050);
        next_cycle();
        #2;
        chk("oor_rd250_rvalid_b", b_rvalid_0, 1'b1);
        chk("oor_rd250_rdata_b", b_Read_data_0, 16'hDEAD);
        next_cycle();
        #2;
        chk("oor_rd50_rdata_b", b_Read_data_0, 16'h5050);
        next_cycle();

        // Read and write together are taken as a write and flagged
        drv0(1'b1, 1'b1, 8'd7, 16'h55AA, 1'b0);
        #2;
        chk("rw_ack0", a_ack_0, 1'b1);
        chk("rw_reqerr0", a_req_err_0, 1'b1);
        chk("rw_reqerr1", a_req_err_1, 1'b0);
        next_cycle();
        drv0(1'b1, 1'b0, 8'd7, 16'h0, 1'b0);
        #2;
        chk("rw_rd_reqerr0", a_req_err_0, 1'b0);
        chk("rw_no_rvalid", a_rvalid_0, 1'b0);
        next_cycle();
        idle();
        #2;
        chk("rw_rvalid", a_rvalid_0, 1'b1);
        chk("rw_rdata", a_Read_data_0, 16'h55AA);
        next_cycle();

        // Parity injection on write, then a clean rewrite
        drv0(1'b0, 1'b1, 8'd9, 16'hFFFF, 1'b1);
        #2;
        chk("par_inj_ack", a_ack_0, 1'b1);
        next_cycle();
        drv0(1'b1, 1'b0, 8'd9, 16'h0, 1'b0);
        next_cycle();
        idle();
        #2;
        chk("par_inj_rvalid", a_rvalid_0, 1'b1);
        chk("par_inj_perr", a_par_err_0, EXP_PERR);
        chk("par_inj_rdata", a_Read_data_0, 16'hFFFF);
        next_cycle();
        drv0(1'b0, 1'b1, 8'd9, 16'hFFFF, 1'b0);
        next_cycle();
        drv0(1'b1, 1'b0, 8'd9, 16'h0, 1'b0);
        next_cycle();
        idle();
        #2;
        chk("par_clean_rvalid", a_rvalid_0, 1'b1);
        chk("par_clean_perr", a_par_err_0, 1'b0);
        next_cycle();
        next_cycle();
        next_cycle();

        // Reset while a READ_LAT=3 read is in flight: its rvalid never appears
        drv0(1'b1, 1'b0, 8'd5, 16'h0, 1'b0);
        #2;
        chk("rstmid_ack_b", b_ack_0, 1'b1);
        next_cycle();
        idle();
        rst = 1'b1;
        #2;
        chk("rstmid_busy_b", b_busy, 1'b1);
        chk("rstmid_rvalid_a", a_rvalid_0, 1'b1);
        next_cycle();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #2;
            chk($sformatf("rstmid_rvalid_b_k%0d", k), b_rvalid_0, 1'b0);
            chk($sformatf("rstmid_busy_b_k%0d", k), b_busy, 1'b0);
            if (k == 0) begin
                chk("rstmid_rdata_b_clr", b_Read_data_0, 16'h0);
                chk("rstmid_rdata_a_clr", a_Read_data_0, 16'h0);
            end
            next_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
